// File: rtl/fire_control_unit.sv
// Fire control unit: acquires and holds a radar lock, issues a single fire
// request per trigger press to the weapons unit, and enforces a post-shot cooldown.
module fire_control_unit #(
    parameter int unsigned LOCK_CYCLES     = 4,
    parameter int unsigned LOSS_CYCLES     = 2,
    parameter logic [7:0]  MAX_RANGE       = 8'd200,
    parameter int unsigned ACK_TIMEOUT     = 8,
    parameter int unsigned COOLDOWN_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       radar_detect,
    input  logic [7:0] target_range,
    input  logic       trigger,
    input  logic       launch_missile,
    input  logic [3:0] remaining_missiles,
    input  logic [1:0] WCU_state,
    output logic       target_locked,
    output logic       fire_command,
    output logic [2:0] FCU_state,
    output logic [3:0] shots_fired,
    output logic       fire_fault
);

    typedef enum logic [2:0] {
        SEARCH   = 3'b000,
        ACQUIRE  = 3'b001,
        LOCKED   = 3'b010,
        FIRING   = 3'b011,
        WAIT_ACK = 3'b100,
        COOLDOWN = 3'b101,
        HOLD     = 3'b110
    } state_t;

    state_t     state;
    logic [7:0] lock_cnt;
    logic [7:0] loss_cnt;
    logic [7:0] ack_timer;
    logic [7:0] cd_timer;
    logic       trig_q;

    logic valid_detect;
    logic trig_edge;
    logic hold_req;
    logic lock_lost;

    always_comb begin
        valid_detect = radar_detect && (target_range != '0) && (target_range <= MAX_RANGE);
        trig_edge    = trigger && !trig_q;
        hold_req     = (remaining_missiles == '0) || (WCU_state == 2'b11);
        lock_lost    = !valid_detect && (loss_cnt == 8'(LOSS_CYCLES - 1));
    end

    assign FCU_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= SEARCH;
            target_locked <= 1'b0;
            fire_command  <= 1'b0;
            shots_fired   <= '0;
            fire_fault    <= 1'b0;
            lock_cnt      <= '0;
            loss_cnt      <= '0;
            ack_timer     <= '0;
            cd_timer      <= '0;
            trig_q        <= 1'b0;
        end else begin
            trig_q <= trigger;
            // An outstanding fire request is never abandoned for an ammo/WCU hold.
            if (hold_req && state != WAIT_ACK) begin
                state         <= HOLD;
                target_locked <= 1'b0;
                fire_command  <= 1'b0;
            end else begin
                case (state)
                    SEARCH: begin
                        if (valid_detect) begin
                            state    <= ACQUIRE;
                            lock_cnt <= 8'd1;
                        end else begin
                            lock_cnt <= '0;
                        end
                    end
                    ACQUIRE: begin
                        if (valid_detect) begin
                            lock_cnt <= lock_cnt + 8'd1;
                            if (lock_cnt + 8'd1 == 8'(LOCK_CYCLES)) begin
                                state         <= LOCKED;
                                target_locked <= 1'b1;
                                loss_cnt      <= '0;
                            end
                        end else begin
                            state    <= SEARCH;
                            lock_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        loss_cnt <= valid_detect ? '0 : loss_cnt + 8'd1;
                        if (lock_lost) begin
                            state         <= SEARCH;
                            target_locked <= 1'b0;
                            loss_cnt      <= '0;
                            lock_cnt      <= '0;
                        end else if (trig_edge && WCU_state == 2'b01) begin
                            state <= FIRING;
                        end
                    end
                    FIRING: begin
                        fire_command <= 1'b1;
                        ack_timer    <= '0;
                        state        <= WAIT_ACK;
                    end
                    WAIT_ACK: begin
                        target_locked <= 1'b1;
                        if (launch_missile) begin
                            fire_command <= 1'b0;
                            if (shots_fired != 4'hF)
                                shots_fired <= shots_fired + 4'd1;
                            cd_timer <= '0;
                            state    <= COOLDOWN;
                        end else if (ack_timer == 8'(ACK_TIMEOUT - 1)) begin
                            fire_command <= 1'b0;
                            fire_fault   <= 1'b1;
                            cd_timer     <= '0;
                            state        <= COOLDOWN;
                        end else begin
                            ack_timer <= ack_timer + 8'd1;
                        end
                    end
                    COOLDOWN: begin
                        loss_cnt <= valid_detect ? '0 : loss_cnt + 8'd1;
                        if (lock_lost) begin
                            state         <= SEARCH;
                            target_locked <= 1'b0;
                            loss_cnt      <= '0;
                            lock_cnt      <= '0;
                        end else if (cd_timer == 8'(COOLDOWN_CYCLES - 1)) begin
                            state <= target_locked ? LOCKED : SEARCH;
                        end else begin
                            cd_timer <= cd_timer + 8'd1;
                        end
                    end
                    HOLD: begin
                        target_locked <= 1'b0;
                        fire_command  <= 1'b0;
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fire_control_unit.sv
// Scenario bench for fire_control_unit: per-cycle stimulus rows carry the expected
// output vector {state, locked, fire, shots, fault}, queued as driven and compared after each edge.
module tb_fire_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       radar_detect;
    logic [7:0] target_range;
    logic       trigger;
    logic       launch_missile;
    logic [3:0] remaining_missiles;
    logic [1:0] WCU_state;
    logic       target_locked;
    logic       fire_command;
    logic [2:0] FCU_state;
    logic [3:0] shots_fired;
    logic       fire_fault;

    always #5 clk = ~clk;

    fire_control_unit #(
        .LOCK_CYCLES    (4),
        .LOSS_CYCLES    (2),
        .MAX_RANGE      (8'd200),
        .ACK_TIMEOUT    (8),
        .COOLDOWN_CYCLES(16)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .radar_detect      (radar_detect),
        .target_range      (target_range),
        .trigger           (trigger),
        .launch_missile    (launch_missile),
        .remaining_missiles(remaining_missiles),
        .WCU_state         (WCU_state),
        .target_locked     (target_locked),
        .fire_command      (fire_command),
        .FCU_state         (FCU_state),
        .shots_fired       (shots_fired),
        .fire_fault        (fire_fault)
    );

    localparam logic [2:0] S = 3'b000, A = 3'b001, L = 3'b010, F = 3'b011,
                           W = 3'b100, C = 3'b101, H = 3'b110;

    typedef struct {
        logic       rst;
        logic       det;
        logic [7:0] rng;
        logic       trg;
        logic       lm;
        logic [3:0] rem;
        logic [1:0] wcu;
        logic [9:0] exp;
    } row_t;

    row_t       rows[$];
    logic [9:0] exp_q[$];
    logic [9:0] obs_q[$];
    int         tests = 0;
    int         fails = 0;
    logic [3:0] cur_rem = 4'd5;
    logic [1:0] cur_wcu = 2'b01;

    function automatic row_t r(input logic rs, input logic det, input logic [7:0] rng,
                               input logic trg, input logic lm, input logic [2:0] st,
                               input logic tl, input logic fc, input logic [3:0] sh,
                               input logic ff);
        row_t x;
        x.rst = rs;  x.det = det; x.rng = rng; x.trg = trg; x.lm = lm;
        x.rem = cur_rem; x.wcu = cur_wcu;
        x.exp = {st, tl, fc, sh, ff};
        return x;
    endfunction

    // Reset then four valid detects at range 100: lock declared on the 4th edge.
    task automatic add_lock();
        rows.push_back(r(1, 0, 8'd0, 0, 0, S, 0, 0, 4'd0, 0));
        for (int i = 0; i < 3; i++) rows.push_back(r(0, 1, 8'd100, 0, 0, A, 0, 0, 4'd0, 0));
        rows.push_back(r(0, 1, 8'd100, 0, 0, L, 1, 0, 4'd0, 0));
    endtask

    task automatic drive_rows();
        foreach (rows[i]) begin
            rst                = rows[i].rst;
            radar_detect       = rows[i].det;
            target_range       = rows[i].rng;
            trigger            = rows[i].trg;
            launch_missile     = rows[i].lm;
            remaining_missiles = rows[i].rem;
            WCU_state          = rows[i].wcu;
            exp_q.push_back(rows[i].exp);
            @(posedge clk);
            #1;
            obs_q.push_back({FCU_state, target_locked, fire_command, shots_fired, fire_fault});
        end
        rows.delete();
    endtask

    task automatic test_reset();
        logic [9:0] e, o;
        int idx = 0;
        rows.push_back(r(1, 1, 8'd100, 1, 1, S, 0, 0, 4'd0, 0));
        rows.push_back(r(1, 0, 8'd0, 0, 0, S, 0, 0, 4'd0, 0));
        rows.push_back(r(0, 1, 8'd100, 0, 0, A, 0, 0, 4'd0, 0));
        drive_rows();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL test_reset[%0d]: observed %b, required %b (state,locked,fire,shots,fault)", idx, o, e);
            end
            idx++;
        end
    endtask

    task automatic test_lock();
        logic [9:0] e, o;
        int idx = 0;
        add_lock();
        rows.push_back(r(0, 1, 8'd100, 0, 0, L, 1, 0, 4'd0, 0));
        rows.push_back(r(1, 0, 8'd0, 0, 0, S, 0, 0, 4'd0, 0));
        for (int i = 0; i < 4; i++) rows.push_back(r(0, 1, 8'd201, 0, 0, S, 0, 0, 4'd0, 0));
        rows.push_back(r(0, 1, 8'd0, 0, 0, S, 0, 0, 4'd0, 0));
        rows.push_back(r(0, 1, 8'd200, 0, 0, A, 0, 0, 4'd0, 0));
        rows.push_back(r(0, 0, 8'd100, 0, 0, S, 0, 0, 4'd0, 0));
        for (int i = 0; i < 3; i++) rows.push_back(r(0, 1, 8'd50, 0, 0, A, 0, 0, 4'd0, 0));
        rows.push_back(r(0, 1, 8'd255, 0, 0, S, 0, 0, 4'd0, 0));
        for (int i = 0; i < 3; i++) rows.push_back(r(0, 1, 8'd1, 0, 0, A, 0, 0, 4'd0, 0));
        rows.push_back(r(0, 1, 8'd1, 0, 0, L, 1, 0, 4'd0, 0));
        drive_rows();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL test_lock[%0d]: observed %b, required %b (state,locked,fire,shots,fault)", idx, o, e);
            end
            idx++;
        end
    endtask

    // Trigger stays high through the whole shot and cooldown: exactly one fire.
    task automatic test_fire();
        logic [9:0] e, o;
        int idx = 0;
        add_lock();
        rows.push_back(r(0, 1, 8'd100, 1, 0, F, 1, 0, 4'd0, 0));
        rows.push_back(r(0, 1, 8'd100, 1, 0, W, 1, 1, 4'd0, 0));
        rows.push_back(r(0, 1, 8'd100, 1, 0, W, 1, 1, 4'd0, 0));
        rows.push_back(r(0, 1, 8'd100, 1, 1, C, 1, 0, 4'd1, 0));
        for (int i = 0; i < 15; i++) rows.push_back(r(0, 1, 8'd100, 1, 0, C, 1, 0, 4'd1, 0));
        for (int i = 0; i < 4; i++) rows.push_back(r(0, 1, 8'd100, 1, 0, L, 1, 0, 4'd1, 0));
        rows.push_back(r(0, 1, 8'd100, 0, 0, L, 1, 0, 4'd1, 0));
        rows.push_back(r(0, 1, 8'd100, 1, 0, F, 1, 0, 4'd1, 0));
        drive_rows();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL test_fire[%0d]: observed %b, required %b (state,locked,fire,shots,fault)", idx, o, e);
            end
            idx++;
        end
    endtask

    // No acknowledge with radar dropping out in WAIT_ACK; trigger toggled during cooldown.
    task automatic test_timeout();
        logic [9:0] e, o;
        int idx = 0;
        add_lock();
        rows.push_back(r(0, 1, 8'd100, 1, 0, F, 1, 0, 4'd0, 0));
        rows.push_back(r(0, 1, 8'd100, 1, 0, W, 1, 1, 4'd0, 0));
        for (int i = 0; i < 7; i++) rows.push_back(r(0, 0, 8'd0, 1, 0, W, 1, 1, 4'd0, 0));
        rows.push_back(r(0, 0, 8'd0, 1, 0, C, 1, 0, 4'd0, 1));
        for (int i = 0; i < 15; i++) rows.push_back(r(0, 1, 8'd100, 1'(i % 2), 0, C, 1, 0, 4'd0, 1));
        rows.push_back(r(0, 1, 8'd100, 0, 0, L, 1, 0, 4'd0, 1));
        rows.push_back(r(0, 1, 8'd100, 1, 0, F, 1, 0, 4'd0, 1));
        drive_rows();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL test_timeout[%0d]: observed %b, required %b (state,locked,fire,shots,fault)", idx, o, e);
            end
            idx++;
        end
    endtask

    task automatic test_loss();
        logic [9:0] e, o;
        int idx = 0;
        add_lock();
        rows.push_back(r(0, 0, 8'd100, 0, 0, L, 1, 0, 4'd0, 0));
        rows.push_back(r(0, 1, 8'd100, 0, 0, L, 1, 0, 4'd0, 0));
        rows.push_back(r(0, 0, 8'd100, 0, 0, L, 1, 0, 4'd0, 0));
        rows.push_back(r(0, 0, 8'd100, 1, 0, S, 0, 0, 4'd0, 0));
        rows.push_back(r(0, 0, 8'd100, 1, 0, S, 0, 0, 4'd0, 0));
        drive_rows();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL test_loss[%0d]: observed %b, required %b (state,locked,fire,shots,fault)", idx, o, e);
            end
            idx++;
        end
    endtask

    task automatic test_wcu_gate();
        logic [9:0] e, o;
        int idx = 0;
        add_lock();
        cur_wcu = 2'b00;
        rows.push_back(r(0, 1, 8'd100, 1, 0, L, 1, 0, 4'd0, 0));
        rows.push_back(r(0, 1, 8'd100, 1, 0, L, 1, 0, 4'd0, 0));
        cur_wcu = 2'b10;
        rows.push_back(r(0, 1, 8'd100, 0, 0, L, 1, 0, 4'd0, 0));
        rows.push_back(r(0, 1, 8'd100, 1, 0, L, 1, 0, 4'd0, 0));
        cur_wcu = 2'b01;
        rows.push_back(r(0, 1, 8'd100, 0, 0, L, 1, 0, 4'd0, 0));
        rows.push_back(r(0, 0, 8'd100, 1, 0, F, 1, 0, 4'd0, 0));
        drive_rows();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL test_wcu_gate[%0d]: observed %b, required %b (state,locked,fire,shots,fault)", idx, o, e);
            end
            idx++;
        end
    endtask

    task automatic test_hold();
        logic [9:0] e, o;
        int idx = 0;
        add_lock();
        cur_rem = 4'd0;
        rows.push_back(r(0, 1, 8'd100, 0, 0, H, 0, 0, 4'd0, 0));
        cur_rem = 4'd5;
        rows.push_back(r(0, 1, 8'd100, 1, 0, H, 0, 0, 4'd0, 0));
        rows.push_back(r(0, 1, 8'd100, 0, 1, H, 0, 0, 4'd0, 0));
        rows.push_back(r(0, 1, 8'd100, 1, 0, H, 0, 0, 4'd0, 0));
        rows.push_back(r(1, 1, 8'd100, 0, 0, S, 0, 0, 4'd0, 0));
        rows.push_back(r(0, 1, 8'd100, 0, 0, A, 0, 0, 4'd0, 0));
        cur_wcu = 2'b11;
        rows.push_back(r(0, 1, 8'd100, 0, 0, H, 0, 0, 4'd0, 0));
        cur_wcu = 2'b01;
        add_lock();
        rows.push_back(r(0, 1, 8'd100, 1, 0, F, 1, 0, 4'd0, 0));
        rows.push_back(r(0, 1, 8'd100, 1, 0, W, 1, 1, 4'd0, 0));
        cur_rem = 4'd0;
        rows.push_back(r(0, 1, 8'd100, 1, 0, W, 1, 1, 4'd0, 0));
        rows.push_back(r(0, 1, 8'd100, 1, 1, C, 1, 0, 4'd1, 0));
        rows.push_back(r(0, 1, 8'd100, 1, 0, H, 0, 0, 4'd1, 0));
        cur_rem = 4'd5;
        drive_rows();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL test_hold[%0d]: observed %b, required %b (state,locked,fire,shots,fault)", idx, o, e);
            end
            idx++;
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [9:0] e, o;
        int idx = 0;
        add_lock();
        rows.push_back(r(0, 1, 8'd100, 1, 0, F, 1, 0, 4'd0, 0));
        rows.push_back(r(0, 1, 8'd100, 1, 0, W, 1, 1, 4'd0, 0));
        rows.push_back(r(1, 1, 8'd100, 1, 1, S, 0, 0, 4'd0, 0));
        rows.push_back(r(0, 0, 8'd0, 0, 0, S, 0, 0, 4'd0, 0));
        drive_rows();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL test_reset_mid_wait[%0d]: observed %b, required %b (state,locked,fire,shots,fault)", idx, o, e);
            end
            idx++;
        end
    endtask

    task automatic test_saturation();
        logic [9:0] e, o;
        logic [3:0] after;
        int idx = 0;
        add_lock();
        for (int k = 1; k <= 16; k++) begin
            after = (k > 15) ? 4'd15 : 4'(k);
            rows.push_back(r(0, 1, 8'd100, 1, 0, F, 1, 0, 4'(k - 1), 0));
            rows.push_back(r(0, 1, 8'd100, 0, 0, W, 1, 1, 4'(k - 1), 0));
            rows.push_back(r(0, 1, 8'd100, 0, 1, C, 1, 0, after, 0));
            for (int i = 0; i < 15; i++) rows.push_back(r(0, 1, 8'd100, 0, 0, C, 1, 0, after, 0));
            rows.push_back(r(0, 1, 8'd100, 0, 0, L, 1, 0, after, 0));
        end
        drive_rows();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL test_saturation[%0d]: observed %b, required %b (state,locked,fire,shots,fault)", idx, o, e);
            end
            idx++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the summary, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; radar_detect = 1'b0; target_range = '0; trigger = 1'b0;
        launch_missile = 1'b0; remaining_missiles = 4'd5; WCU_state = 2'b01;
        test_reset();
        test_lock();
        test_fire();
        test_timeout();
        test_loss();
        test_wcu_gate();
        test_hold();
        test_reset_mid_wait();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fire_control_unit.md
FIRE_CONTROL_UNIT -- requirements
Module: fire_control_unit

Interface
REQ-001 Reset rst SHALL be synchronous and active-high; the clock SHALL be clk. All state SHALL update on posedge clk only.
REQ-002 Parameter LOCK_CYCLES, default 4, SHALL set the consecutive valid-detect cycles needed to declare lock.
REQ-003 Parameter LOSS_CYCLES, default 2, SHALL set the consecutive invalid-detect cycles that break lock.
REQ-004 Parameter MAX_RANGE, default 8'd200, SHALL set the maximum engageable range (inclusive).
REQ-005 Parameter ACK_TIMEOUT, default 8, SHALL set the WAIT_ACK cycles allowed before fault.
REQ-006 Parameter COOLDOWN_CYCLES, default 16, SHALL set the post-shot inhibit length.
REQ-007 Ports, one per line:
 clk  in  1  system clock
 rst  in  1  synchronous active-high reset
 radar_detect  in  1  radar reports a contact this cycle
 target_range  in  8  contact range, unsigned
 trigger  in  1  pilot trigger level
 launch_missile  in  1  weapons-unit launch acknowledge
 remaining_missiles  in  4  weapons-unit ammo count
 WCU_state  in  2  weapons-unit state (00 IDLE, 01 LOCKED, 10 FIRE, 11 OUT_OF_AMMO)
 target_locked  out  1  lock indication to weapons unit
 fire_command  out  1  fire request to weapons unit
 FCU_state  out  3  current state encoding
 shots_fired  out  4  acknowledged launches, saturating
 fire_fault  out  1  sticky acknowledge-timeout flag

Function
REQ-008 valid_detect SHALL be radar_detect=1 AND target_range!=0 AND target_range<=MAX_RANGE.
REQ-009 trig_edge SHALL be trigger AND NOT trigger registered one cycle earlier; a held trigger SHALL produce exactly one edge.
REQ-010 States SHALL be SEARCH 000, ACQUIRE 001, LOCKED 010, FIRING 011, WAIT_ACK 100, COOLDOWN 101, HOLD 110; FCU_state SHALL equal the current encoding.
REQ-011 SEARCH: on valid_detect -> ACQUIRE with lock_cnt=1; else stay, lock_cnt=0.
REQ-012 ACQUIRE: valid_detect increments lock_cnt; when lock_cnt reaches LOCK_CYCLES -> LOCKED, target_locked=1 registered in the same edge; invalid detect -> SEARCH, lock_cnt=0.
REQ-013 With LOCK_CYCLES=4, target_locked SHALL rise on the 4th consecutive valid_detect posedge.
REQ-014 LOCKED and COOLDOWN: loss_cnt increments on invalid detect, clears on valid_detect; at LOSS_CYCLES -> SEARCH, target_locked=0.
REQ-015 LOCKED: trig_edge with WCU_state=01 and no lock loss this cycle -> FIRING; trig_edge with WCU_state!=01 SHALL be ignored.
REQ-016 Lock loss SHALL take priority over a simultaneous trig_edge.
REQ-017 FIRING: fire_command=1, -> WAIT_ACK next cycle, ack timer=0.
REQ-018 WAIT_ACK: fire_command SHALL stay 1 until launch_missile=1 or timeout; target_locked SHALL be held 1 and loss_cnt frozen.
REQ-019 WAIT_ACK, launch_missile=1: fire_command=0, shots_fired+1 (saturate at 15), -> COOLDOWN, cooldown timer=0.
REQ-020 WAIT_ACK, ACK_TIMEOUT cycles without launch_missile: fire_command=0, fire_fault=1, -> COOLDOWN, shots_fired unchanged.
REQ-021 COOLDOWN: trig_edge ignored; after COOLDOWN_CYCLES -> LOCKED if target_locked=1, else SEARCH.
REQ-022 remaining_missiles=0 or WCU_state=11 in any state except WAIT_ACK SHALL force HOLD: target_locked=0, fire_command=0; HOLD exits only on rst.
REQ-023 fire_fault SHALL remain 1 until rst.

Reset
REQ-024 rst SHALL override all inputs: state SEARCH, target_locked=0, fire_command=0, shots_fired=0, fire_fault=0, all counters and trigger register 0.
REQ-025 rst asserted mid-WAIT_ACK SHALL drop fire_command on the same edge with no shots_fired update.

Verification
REQ-026 rst, 4 cycles valid_detect range 100 -> target_locked=1 after 4th edge, FCU_state=010; range 201 instead -> stays SEARCH.
REQ-027 Locked, WCU_state=01, trigger 0->1, launch_missile on 2nd WAIT_ACK cycle -> fire_command high 2 cycles, shots_fired=1, COOLDOWN 16 cycles, back to LOCKED.
REQ-028 Locked, trigger edge, launch_missile never -> after 8 WAIT_ACK cycles fire_command=0, fire_fault=1, shots_fired=0.
REQ-029 Locked, 2 invalid detects with trigger edge on 2nd -> SEARCH, target_locked=0, no fire_command.
REQ-030 remaining_missiles=0 while LOCKED -> HOLD, outputs 0; valid_detect/trigger ignored until rst.
REQ-031 Trigger held high through COOLDOWN return to LOCKED -> no second fire_command.
